alu_store_ram: RTL and testbench

- Registered, parametrised ALU with an on-chip result store.
- Each accepted operation is computed in one clock and the result is written into a DEPTH-entry circular result memory.
- Stored results are read back through an independent, synchronous, address-based read port.
- Sits between the operand source and any consumer that needs the history of recent ALU results.

---
 rtl/alu_store_ram_if.sv | 37 +++
 rtl/alu_store_ram.sv | 141 ++++++++++++++
 tb/tb_alu_store_ram.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_store_ram_if.sv
// Operation, result and read-port bundle for alu_store_ram.
// The master drives operations, clear and read requests. The slave returns results, store status and read data.
interface alu_store_ram_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             res_valid;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             bad_op;
    logic             clear;
    logic [AW:0]      count;
    logic             full;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;

    modport master (
        output op_valid, a, b, sel, clear, rd_en, rd_addr,
        input  op_ready, res_valid, res, carry, bad_op, count, full,
               rd_valid, rd_data, rd_err
    );

    modport slave (
        input  op_valid, a, b, sel, clear, rd_en, rd_addr,
        output op_ready, res_valid, res, carry, bad_op, count, full,
               rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/alu_store_ram.sv
// Registered ALU. Every accepted result is also written into a circular store of DEPTH entries.
// The store is read back through a synchronous port addressed relative to the oldest valid entry.
module alu_store_ram #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter bit          OVERWRITE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_store_ram_if.slave   bus
);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             bad_op_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_err_q;

    logic             op_ready_c;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_bad;
    logic [AW-1:0]    oldest;
    logic [AW-1:0]    rd_idx;

    // clear takes priority, so an operation offered in the same cycle is dropped.
    assign op_ready_c = ~rst & (OVERWRITE ? 1'b1 : ~full_q);
    assign accept     = bus.op_valid & op_ready_c & ~bus.clear;

    // When count == DEPTH its low bits are zero, so the oldest entry equals wr_ptr.
    assign oldest = wr_ptr_q - count_q[AW-1:0];
    assign rd_idx = oldest + bus.rd_addr;

    assign sum = {1'b0, bus.a} + {1'b0, bus.b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_bad   = 1'b0;
        case (bus.sel)
            4'b0000: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            4'b0001: begin
                alu_res   = bus.a - bus.b;
                alu_carry = (bus.a < bus.b);
            end
            4'b0110: alu_res = bus.a * bus.b;
            4'b1100: alu_res = bus.a & bus.b;
            4'b1001: alu_res = bus.a | bus.b;
            4'b1101: alu_res = ~(bus.a & bus.b);
            4'b0111: alu_res = ~(bus.a | bus.b);
            4'b1110: alu_res = bus.a ^ bus.b;
            4'b1111: alu_res = ~(bus.a ^ bus.b);
            default: alu_bad = 1'b1;
        endcase
    end

    // The store array has no reset. Only the pointer and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            bad_op_q    <= 1'b0;
        end else begin
            res_valid_q <= accept;
            if (accept) begin
                res_q    <= alu_res;
                carry_q  <= alu_carry;
                bad_op_q <= alu_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else if (accept) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_q <= count_q + CW'(1);
                full_q  <= (count_q == CW'(DEPTH - 1));
            end
        end
    end

    // Reads use the pre-edge pointer, count and memory, which gives read-before-write ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if ({1'b0, bus.rd_addr} >= count_q) begin
                    rd_err_q  <= 1'b1;
                    rd_data_q <= '0;
                end else begin
                    rd_err_q  <= 1'b0;
                    rd_data_q <= mem[rd_idx];
                end
            end
        end
    end

    assign bus.op_ready  = op_ready_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res       = res_q;
    assign bus.carry     = carry_q;
    assign bus.bad_op    = bad_op_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_alu_store_ram.sv
// Directed bench for alu_store_ram. One instance overwrites when the store is full and one blocks when full.
// Both instances receive the same stimulus.
module tb_alu_store_ram;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] sel = '0;
    logic       clear = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_addr = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_store_ram_if #(.WIDTH(8), .DEPTH(8)) if1 ();
    alu_store_ram_if #(.WIDTH(8), .DEPTH(8)) if0 ();

    assign if1.op_valid = op_valid;
    assign if1.a        = a;
    assign if1.b        = b;
    assign if1.sel      = sel;
    assign if1.clear    = clear;
    assign if1.rd_en    = rd_en;
    assign if1.rd_addr  = rd_addr;
    assign if0.op_valid = op_valid;
    assign if0.a        = a;
    assign if0.b        = b;
    assign if0.sel      = sel;
    assign if0.clear    = clear;
    assign if0.rd_en    = rd_en;
    assign if0.rd_addr  = rd_addr;

    alu_store_ram #(.WIDTH(8), .DEPTH(8), .OVERWRITE(1'b1)) u_ovw (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );
    alu_store_ram #(.WIDTH(8), .DEPTH(8), .OVERWRITE(1'b0)) u_blk (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_res;
        logic       exp_carry;
        logic       exp_bad;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vs);
        op_valid = 1'b1;
        a = va;
        b = vb;
        sel = vs;
        step();
        op_valid = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] addr);
        rd_en = 1'b1;
        rd_addr = addr;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{8'hFF, 8'h02, 4'b0000, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{8'h03, 8'h05, 4'b0001, 8'hFE, 1'b1, 1'b0};
        vecs[2]  = '{8'h10, 8'h11, 4'b0110, 8'h10, 1'b0, 1'b0};
        vecs[3]  = '{8'h12, 8'h34, 4'b0010, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{8'hC3, 8'h0F, 4'b1100, 8'h03, 1'b0, 1'b0};
        vecs[5]  = '{8'hA0, 8'h05, 4'b1001, 8'hA5, 1'b0, 1'b0};
        vecs[6]  = '{8'hF0, 8'h0F, 4'b1101, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{8'hF0, 8'h0F, 4'b0111, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'hAA, 8'hFF, 4'b1110, 8'h55, 1'b0, 1'b0};
        vecs[9]  = '{8'hAA, 8'hFF, 4'b1111, 8'hAA, 1'b0, 1'b0};
        vecs[10] = '{8'h05, 8'h03, 4'b0001, 8'h02, 1'b0, 1'b0};
        vecs[11] = '{8'h80, 8'h80, 4'b0000, 8'h00, 1'b1, 1'b0};

        // Reset state
        step();
        step();
        chk("rst_res_valid", 32'(if1.res_valid), 32'd0);
        chk("rst_res", 32'(if1.res), 32'd0);
        chk("rst_count", 32'(if1.count), 32'd0);
        chk("rst_full", 32'(if1.full), 32'd0);
        chk("rst_rd_valid", 32'(if1.rd_valid), 32'd0);
        chk("rst_op_ready", 32'(if1.op_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("op_ready_ovw", 32'(if1.op_ready), 32'd1);
        chk("op_ready_blk", 32'(if0.op_ready), 32'd1);

        // First accepted operation
        do_op(8'h0F, 8'h01, 4'b0000);
        chk("first_res_valid", 32'(if1.res_valid), 32'd1);
        chk("first_res", 32'(if1.res), 32'h10);
        chk("first_carry", 32'(if1.carry), 32'd0);
        chk("first_count", 32'(if1.count), 32'd1);
        chk("first_count_blk", 32'(if0.count), 32'd1);
        step();
        chk("res_valid_pulse", 32'(if1.res_valid), 32'd0);

        // Opcode table
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sel);
            chk($sformatf("vec%0d_valid", i), 32'(if1.res_valid), 32'd1);
            chk($sformatf("vec%0d_res", i), 32'(if1.res), 32'(vecs[i].exp_res));
            chk($sformatf("vec%0d_carry", i), 32'(if1.carry), 32'(vecs[i].exp_carry));
            chk($sformatf("vec%0d_bad", i), 32'(if1.bad_op), 32'(vecs[i].exp_bad));
        end

        // Fill both stores: the overwrite instance wraps and the blocking instance stops at 8
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_count_ovw", 32'(if1.count), 32'd0);
        chk("clear_count_blk", 32'(if0.count), 32'd0);
        chk("clear_ready_blk", 32'(if0.op_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 8) chk("blk_ready_full", 32'(if0.op_ready), 32'd0);
            op_valid = 1'b1;
            a = 8'(i);
            b = 8'h00;
            sel = 4'b0000;
            step();
        end
        op_valid = 1'b0;
        chk("ovw_count", 32'(if1.count), 32'd8);
        chk("ovw_full", 32'(if1.full), 32'd1);
        chk("ovw_ready", 32'(if1.op_ready), 32'd1);
        chk("ovw_last_res", 32'(if1.res), 32'd9);
        chk("blk_count", 32'(if0.count), 32'd8);
        chk("blk_full", 32'(if0.full), 32'd1);
        chk("blk_res_valid", 32'(if0.res_valid), 32'd0);
        chk("blk_last_res", 32'(if0.res), 32'd7);
        do_read(3'd0);
        chk("ovw_rd0_valid", 32'(if1.rd_valid), 32'd1);
        chk("ovw_rd0_data", 32'(if1.rd_data), 32'd2);
        chk("blk_rd0_data", 32'(if0.rd_data), 32'd0);
        do_read(3'd7);
        chk("ovw_rd7_data", 32'(if1.rd_data), 32'd9);
        chk("ovw_rd7_err", 32'(if1.rd_err), 32'd0);
        chk("blk_rd7_data", 32'(if0.rd_data), 32'd7);
        step();
        chk("rd_valid_pulse", 32'(if1.rd_valid), 32'd0);

        // Out-of-range reads and read/write collisions
        clear = 1'b1;
        step();
        clear = 1'b0;
        do_op(8'h21, 8'h00, 4'b0000);
        do_op(8'h22, 8'h00, 4'b0000);
        do_op(8'h23, 8'h00, 4'b0000);
        chk("three_count", 32'(if1.count), 32'd3);
        do_read(3'd5);
        chk("oor_valid", 32'(if1.rd_valid), 32'd1);
        chk("oor_err", 32'(if1.rd_err), 32'd1);
        chk("oor_data", 32'(if1.rd_data), 32'd0);
        do_read(3'd2);
        chk("rd2_err", 32'(if1.rd_err), 32'd0);
        chk("rd2_data", 32'(if1.rd_data), 32'h23);
        rd_en = 1'b1;
        rd_addr = 3'd3;
        do_op(8'h24, 8'h00, 4'b0000);
        rd_en = 1'b0;
        chk("rbw_err_oldcount", 32'(if1.rd_err), 32'd1);
        chk("rbw_data_oldcount", 32'(if1.rd_data), 32'd0);
        chk("rbw_count_after", 32'(if1.count), 32'd4);
        rd_en = 1'b1;
        rd_addr = 3'd0;
        do_op(8'h25, 8'h00, 4'b0000);
        rd_en = 1'b0;
        chk("rbw_rd0_data", 32'(if1.rd_data), 32'h21);
        chk("rbw_count5", 32'(if1.count), 32'd5);

        // clear beats a simultaneous operation; a read in the same cycle sees the pre-clear store
        clear = 1'b1;
        rd_en = 1'b1;
        rd_addr = 3'd0;
        do_op(8'h77, 8'h00, 4'b0000);
        clear = 1'b0;
        rd_en = 1'b0;
        chk("clr_count", 32'(if1.count), 32'd0);
        chk("clr_res_valid", 32'(if1.res_valid), 32'd0);
        chk("clr_res_held", 32'(if1.res), 32'h25);
        chk("clr_rd_valid", 32'(if1.rd_valid), 32'd1);
        chk("clr_rd_data", 32'(if1.rd_data), 32'h21);

        // Reset with a read request and an operation pending in the same cycle
        do_op(8'h40, 8'h00, 4'b0000);
        rst = 1'b1;
        rd_en = 1'b1;
        rd_addr = 3'd0;
        do_op(8'h41, 8'h00, 4'b0000);
        rd_en = 1'b0;
        chk("rst_mid_rd_valid", 32'(if1.rd_valid), 32'd0);
        chk("rst_mid_res_valid", 32'(if1.res_valid), 32'd0);
        chk("rst_mid_res", 32'(if1.res), 32'd0);
        chk("rst_mid_count", 32'(if1.count), 32'd0);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
